page_window: RTL
================

# page_window

Parametrised page buffer for the voice datapath: a register-based byte memory of `NUM_PAGES` × `PAGE_BYTES` bytes with a byte write port. A requester selects one page. The block either snapshots the whole page onto a wide parallel bus in one cycle, or streams the snapshot out one byte per cycle over a valid/ready handshake. It sits between the sample/coefficient writer and the voice processing stages, replacing fixed 4×16-byte page selection.

## Interface
- `BYTE_W`, default 8, width of one memory byte.
- `PAGE_BYTES`, default 16, bytes per page; must be ≥ 2.
- `NUM_PAGES`, default 4, number of pages; must be ≥ 1; need not be a power of two.
- `PW` (derived), max(1, clog2(`NUM_PAGES`)), page index width.
- `AW` (derived), max(1, clog2(`NUM_PAGES`*`PAGE_BYTES`)), byte address width.
- `clk`  in  1  clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  byte write strobe.
- `wr_addr`  in  `AW`  byte address; page = addr / `PAGE_BYTES`.
- `wr_data`  in  `BYTE_W`  write data.
- `req_valid`  in  1  page request.
- `req_ready`  out  1  request accepted when `req_valid` and `req_ready` are both high.
- `req_page`  in  `PW`  page index.
- `req_mode`  in  1  0 = parallel load, 1 = stream.
- `q`  out  `PAGE_BYTES`*`BYTE_W`  snapshot bus; byte 0 of the page sits in the MSBs.
- `q_valid`  out  1  one-cycle pulse after a parallel load.
- `s_valid`  out  1  stream byte valid.
- `s_ready`  in  1  stream consumer ready.
- `s_data`  out  `BYTE_W`  stream byte.
- `s_last`  out  1  high with the final byte of the page.
- `err`  out  1  one-cycle pulse when an out-of-range page is requested.

## Operation
- Reset (asynchronous, `rst` low):
  - `mem[i]` = i mod 2^`BYTE_W` for every i.
  - Snapshot registers = 0, so `q` = 0.
  - `q_valid`, `s_valid`, `s_last` and `err` = 0.
  - State = IDLE, stream index = 0.
- Write: when `wr_en` is high and `wr_addr` < `NUM_PAGES`*`PAGE_BYTES`, `mem[wr_addr]` ← `wr_data`. Out-of-range addresses are ignored. Writes are accepted in every state.
- State IDLE:
  - `req_ready` = 1.
  - On accept with `req_page` < `NUM_PAGES`: snapshot byte j ← `mem[req_page*PAGE_BYTES + j]` for all j.
  - If `req_mode` = 0, stay in IDLE and pulse `q_valid` next cycle. If `req_mode` = 1, go to STREAM with index = 0.
- Out-of-range accept: `req_page` ≥ `NUM_PAGES` is accepted, pulses `err` next cycle, leaves the snapshot unchanged and stays in IDLE.
- State STREAM:
  - `req_ready` = 0, `s_valid` = 1, `s_data` = snapshot[index], `s_last` = (index == `PAGE_BYTES`-1).
  - On an `s_valid` & `s_ready` handshake, index increments.
  - A handshake with `s_last` high sets index = 0 and returns to IDLE.
- `q` always drives the snapshot registers, in both modes. `q_valid` pulses only for parallel loads.
- Write/snapshot collision: a write in the accept cycle to the requested page is not captured; the snapshot takes the pre-write value. Later writes never alter a snapshot in flight.
- Stream stall: with `s_ready` low, `s_data` and `s_last` hold stable.

## Timing
- Parallel load: accept at edge T; `q` is updated and `q_valid` = 1 during cycle T+1. Back-to-back accepts are allowed every cycle, giving a throughput of one page per cycle.
- Stream: accept at T; byte 0 is valid in T+1. With `s_ready` held high, the last byte is in T+`PAGE_BYTES`, and `req_ready` = 1 again in T+`PAGE_BYTES`+1.
- Reset asserted mid-stream: `s_valid` drops immediately (asynchronous) and the memory is re-initialised.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs except `req_ready`, which is state-only.

## Structure
- Shared package `voice_pkg` holds:
  - the state enum {IDLE, STREAM};
  - a `clog2`-with-minimum-1 function used for `PW` and `AW`.
- Sub-module `page_mem` contains the register array, the reset initialisation, the write port and the combinational page-read mux (`PAGE_BYTES` bytes wide).
- The top level contains the FSM, the snapshot registers, the stream index counter and the output logic.

## Test plan
- Reset, then a parallel request for page 2 (defaults) → `q_valid` pulses for one cycle and `q` = 0x202122…2F.
- Write 0xAB to address 17, then a parallel request for page 1 in the next cycle → `q` = 0x10AB1213…1F. Repeating with the write in the same cycle as the accept → `q` = 0x101112…1F.
- Stream page 3 with `s_ready` toggling 1,0,1,… → bytes 0x30…0x3F arrive in order with no loss or duplication, `s_last` on 0x3F only, and `req_ready` stays low until after the last handshake.
- `NUM_PAGES`=3, request page 3 → `err` pulses, `q` and `q_valid` are unchanged, and the block stays in IDLE.
- Reset asserted mid-stream after byte 5 → `s_valid` goes to 0 at once; after release, a stream of page 0 restarts at 0x00.
- `BYTE_W`=8, `PAGE_BYTES`=64, `NUM_PAGES`=8: reset value at address 300 = 300 mod 256 = 0x2C; a parallel request for page 4 returns bytes 0x00…0x3F.

Source files
------------

// File: rtl/voice_pkg.sv
// Shared definitions for the voice datapath: FSM state encoding and width helpers.
package voice_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/page_window_if.sv
// Write port, page request, snapshot bus and byte stream of the page_window block.
interface page_window_if
  import voice_pkg::*;
#(
  parameter int BYTE_W     = 8,
  parameter int PAGE_BYTES = 16,
  parameter int NUM_PAGES  = 4
);
  localparam int PW = clog2_min1(NUM_PAGES);
  localparam int AW = clog2_min1(NUM_PAGES * PAGE_BYTES);

  logic                         wr_en;
  logic [AW-1:0]                wr_addr;
  logic [BYTE_W-1:0]            wr_data;
  logic                         req_valid;
  logic                         req_ready;
  logic [PW-1:0]                req_page;
  logic                         req_mode;
  logic [PAGE_BYTES*BYTE_W-1:0] q;
  logic                         q_valid;
  logic                         s_valid;
  logic                         s_ready;
  logic [BYTE_W-1:0]            s_data;
  logic                         s_last;
  logic                         err;

  modport master (
    output wr_en, wr_addr, wr_data, req_valid, req_page, req_mode, s_ready,
    input  req_ready, q, q_valid, s_valid, s_data, s_last, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, req_valid, req_page, req_mode, s_ready,
    output req_ready, q, q_valid, s_valid, s_data, s_last, err
  );

endinterface

// File: rtl/page_window_page_mem.sv
// Register-based byte memory with one write port and a combinational whole-page read.
module page_mem
  import voice_pkg::*;
#(
  parameter int BYTE_W     = 8,
  parameter int PAGE_BYTES = 16,
  parameter int NUM_PAGES  = 4,
  parameter int PW         = clog2_min1(NUM_PAGES),
  parameter int AW         = clog2_min1(NUM_PAGES * PAGE_BYTES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [BYTE_W-1:0]            wr_data,
  input  logic [PW-1:0]                rd_page,
  output logic [PAGE_BYTES*BYTE_W-1:0] rd_data
);
  localparam int DEPTH = NUM_PAGES * PAGE_BYTES;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic              rd_ok;

  // NOTE: this is a flop array, not an SRAM macro, so every entry can take an
  // asynchronous reset value; an inferred RAM block could not be reset this way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= BYTE_W'(i);
    end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_ok = int'(rd_page) < NUM_PAGES;

  // Byte 0 of the page lands in the most significant lane.
  for (genvar j = 0; j < PAGE_BYTES; j++) begin : g_rd
    assign rd_data[(PAGE_BYTES-1-j)*BYTE_W +: BYTE_W] =
      rd_ok ? mem[AW'(int'(rd_page) * PAGE_BYTES + j)] : '0;
  end

endmodule

// File: rtl/page_window.sv
// Page snapshot buffer: loads a selected page in parallel or streams it byte by byte.
module page_window
  import voice_pkg::*;
#(
  parameter int BYTE_W     = 8,
  parameter int PAGE_BYTES = 16,
  parameter int NUM_PAGES  = 4
) (
  input logic          clk,
  input logic          rst,
  page_window_if.slave bus
);
  localparam int PW = clog2_min1(NUM_PAGES);
  localparam int AW = clog2_min1(NUM_PAGES * PAGE_BYTES);
  localparam int IW = clog2_min1(PAGE_BYTES);

  state_t                       state;
  logic [PAGE_BYTES*BYTE_W-1:0] snap;
  logic [PAGE_BYTES*BYTE_W-1:0] page_rd;
  logic [IW-1:0]                idx;
  logic                         q_valid_r;
  logic                         err_r;
  logic                         page_ok;
  logic                         at_last;
  logic [BYTE_W-1:0]            snap_b [PAGE_BYTES];

  page_mem #(
    .BYTE_W    (BYTE_W),
    .PAGE_BYTES(PAGE_BYTES),
    .NUM_PAGES (NUM_PAGES),
    .PW        (PW),
    .AW        (AW)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (bus.wr_en),
    .wr_addr(bus.wr_addr),
    .wr_data(bus.wr_data),
    .rd_page(bus.req_page),
    .rd_data(page_rd)
  );

  assign page_ok = int'(bus.req_page) < NUM_PAGES;
  assign at_last = (idx == IW'(PAGE_BYTES - 1));

  // The memory read is sampled before this edge's write lands, so a write in
  // the accept cycle is never part of the snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      snap      <= '0;
      idx       <= '0;
      q_valid_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      q_valid_r <= 1'b0;
      err_r     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (!page_ok) begin
              err_r <= 1'b1;
            end else begin
              snap <= page_rd;
              if (bus.req_mode) begin
                state <= STREAM;
                idx   <= '0;
              end else begin
                q_valid_r <= 1'b1;
              end
            end
          end
        end
        STREAM: begin
          if (bus.s_ready) begin
            if (at_last) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar j = 0; j < PAGE_BYTES; j++) begin : g_byte
    assign snap_b[j] = snap[(PAGE_BYTES-1-j)*BYTE_W +: BYTE_W];
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.q         = snap;
  assign bus.q_valid   = q_valid_r;
  assign bus.err       = err_r;
  assign bus.s_valid   = (state == STREAM);
  assign bus.s_data    = snap_b[idx];
  assign bus.s_last    = (state == STREAM) && at_last;

endmodule
